// File: rtl/booth_seq_mul.sv
// Iterative signed radix-4 Booth multiplier: one partial product per cycle,
// size/2 cycles per product, valid/ready handshakes on both sides.
module booth_seq_mul #(
    parameter int size = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [size-1:0]     multiplicand,
    input  logic [size-1:0]     multiplier,
    input  logic                abort,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*size-1:0]   product,
    output logic                busy
);

    localparam int CW = (size / 2 > 1) ? $clog2(size / 2) : 1;
    localparam int PW = size + 1;
    localparam int AW = 2 * size;
    localparam logic [CW-1:0] LAST = CW'(size / 2 - 1);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [AW-1:0]   product_q, product_d;
    logic [size-1:0] a_q, a_d;
    logic [size-1:0] b_q, b_d;

    logic [size:0]   bExt;
    logic [2:0]      group;
    logic [PW-1:0]   aExt;
    logic [PW-1:0]   mag;
    logic [PW-1:0]   pp;
    logic            neg;
    logic [AW-1:0]   ppExt;
    logic [CW:0]     shAmt;
    logic [AW-1:0]   accSum;

    // B[-1] is the appended zero; group k sits at bits 2k+1..2k-1 of B.
    always_comb begin
        bExt  = {b_q, 1'b0};
        group = '0;
        for (int k = 0; k < size / 2; k++) begin
            if (cnt_q == CW'(k)) begin
                group = bExt[2*k +: 3];
            end
        end
    end

    always_comb begin
        aExt = {a_q[size-1], a_q};
        mag  = '0;
        neg  = 1'b0;
        case (group)
            3'b001, 3'b010: begin mag = aExt;          neg = 1'b0; end
            3'b011:         begin mag = {a_q, 1'b0};   neg = 1'b0; end
            3'b100:         begin mag = {a_q, 1'b0};   neg = 1'b1; end
            3'b101, 3'b110: begin mag = aExt;          neg = 1'b1; end
            default:        begin mag = '0;            neg = 1'b0; end
        endcase
        pp = neg ? ~mag : mag;
        // Extending the inverted value before adding the correction keeps -2A
        // exact even when A is the most negative operand.
        ppExt  = {{(AW - PW){pp[PW-1]}}, pp};
        shAmt  = {cnt_q, 1'b0};
        accSum = acc_q + (ppExt << shAmt) + (AW'(neg) << shAmt);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        product_d = product_q;
        a_d       = a_q;
        b_d       = b_q;
        case (state_q)
            IDLE: begin
                if (in_valid && !abort) begin
                    a_d     = multiplicand;
                    b_d     = multiplier;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    acc_d = accSum;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        product_d = accSum;
                        cnt_d     = '0;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                if (abort || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            product_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            a_q       <= a_d;
            b_q       <= b_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = product_q;

endmodule

// File: tb/tb_booth_seq_mul.sv
// Directed and random checks for booth_seq_mul (size=8): reset, latency,
// sign corners, back-pressure, abort and back-to-back operation.
module tb_booth_seq_mul;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  multiplicand = '0;
    logic [7:0]  multiplier = '0;
    logic        abort = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] product;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int acceptCount = 0;
    int retireCount = 0;

    booth_seq_mul #(.size(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .multiplicand(multiplicand), .multiplier(multiplier), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .product(product),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Independent handshake counters used by the back-to-back scenario.
    always @(posedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready && !abort) acceptCount++;
            if (out_valid && out_ready) retireCount++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, then presents one operand pair for one edge
    // and scrambles the operand buses afterwards.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        in_valid     = 1'b1;
        multiplicand = a;
        multiplier   = b;
        step();
        in_valid     = 1'b0;
        multiplicand = 8'($urandom);
        multiplier   = 8'($urandom);
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (!out_valid && edges < 20) begin
            step();
            edges++;
        end
    endtask

    task automatic test_reset();
        int lat;
        rst = 1'b1;
        step();
        step();
        checks++; if (product !== 16'h0000) begin errors++; $display("[TB] FAIL reset_product got=%h exp=0000", product); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
        rst = 1'b0;
        step();
        applyStimulus(8'd5, 8'd7);
        step();
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midrun_busy got=%b exp=1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (product !== 16'h0000) begin errors++; $display("[TB] FAIL midrun_rst_product got=%h exp=0000", product); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrun_rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrun_rst_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrun_rst_in_ready got=%b exp=1", in_ready); end
        step();
        rst = 1'b0;
        step();
        out_ready = 1'b1;
        applyStimulus(8'd1, 8'd1);
        wait_done(lat);
        checks++; if (product !== 16'h0001 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL after_reset_1x1 got=%h valid=%b exp=0001 valid=1", product, out_valid); end
        step();
    endtask

    task automatic test_basic();
        int lat;
        out_ready = 1'b1;
        applyStimulus(8'd3, 8'd5);
        wait_done(lat);
        checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL basic_latency got=%0d exp=4", lat); end
        checks++; if (product !== 16'h000F) begin errors++; $display("[TB] FAIL basic_3x5 got=%h exp=000F", product); end
        step();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_retire in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
    endtask

    task automatic test_corners();
        logic [7:0]  aTab [4] = '{8'h80, 8'h80, 8'h7F, 8'hFF};
        logic [7:0]  bTab [4] = '{8'h80, 8'h7F, 8'h7F, 8'hFF};
        logic [15:0] eTab [4] = '{16'h4000, 16'hC080, 16'h3F01, 16'h0001};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(aTab[i], bTab[i]);
            wait_done(lat);
            checks++; if (product !== eTab[i] || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL corner_%0d got=%h valid=%b exp=%h", i, product, out_valid, eTab[i]); end
            step();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        out_ready = 1'b0;
        applyStimulus(8'hF9, 8'd9);
        wait_done(lat);
        in_valid     = 1'b1;
        multiplicand = 8'd1;
        multiplier   = 8'd1;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || product !== 16'hFFC1 || in_ready !== 1'b0) bad++;
            step();
        end
        in_valid = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL backpressure_hold bad_cycles=%0d exp=0 product=%h", bad, product); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 16'hFFC1) begin errors++; $display("[TB] FAIL backpressure_retire valid=%b ready=%b product=%h exp 0/1/FFC1", out_valid, in_ready, product); end
    endtask

    task automatic test_abort();
        int lat;
        int rose = 0;
        out_ready = 1'b1;
        applyStimulus(8'd10, 8'd10);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || product !== 16'hFFC1) begin errors++; $display("[TB] FAIL abort_run busy=%b ready=%b product=%h exp 0/1/FFC1", busy, in_ready, product); end
        for (int i = 0; i < 6; i++) begin
            if (out_valid !== 1'b0) rose++;
            step();
        end
        checks++; if (rose !== 0) begin errors++; $display("[TB] FAIL abort_no_valid cycles=%0d exp=0", rose); end
        applyStimulus(8'd2, 8'hFD);
        wait_done(lat);
        checks++; if (product !== 16'hFFFA) begin errors++; $display("[TB] FAIL abort_next_2x-3 got=%h exp=FFFA", product); end
        step();
        abort        = 1'b1;
        in_valid     = 1'b1;
        multiplicand = 8'd4;
        multiplier   = 8'd4;
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_blocks_accept busy=%b exp=0", busy); end
        out_ready = 1'b0;
        applyStimulus(8'd6, 8'd6);
        wait_done(lat);
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || product !== 16'h0024) begin errors++; $display("[TB] FAIL abort_done valid=%b busy=%b product=%h exp 0/0/0024", out_valid, busy, product); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int acc0 = acceptCount;
        int ret0 = retireCount;
        logic [7:0]  a, b;
        logic [15:0] exp;
        for (int n = 0; n < 1000; n++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            exp = 16'($signed(a) * $signed(b));
            out_ready = 1'b0;
            applyStimulus(a, b);
            wait_done(lat);
            checks++; if (product !== exp || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL random_%0d a=%h b=%h got=%h exp=%h", n, a, b, product, exp); end
            for (int g = int'($urandom_range(0, 3)); g > 0; g--) step();
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        checks++; if ((acceptCount - acc0) !== 1000 || (retireCount - ret0) !== 1000) begin errors++; $display("[TB] FAIL random_counts accepts=%0d retires=%0d exp=1000", acceptCount - acc0, retireCount - ret0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/booth_seq_mul.md
Name: booth_seq_mul

Overview:
- Iterative signed radix-4 Booth multiplier sequencer.
- Accepts one operand pair over a valid/ready handshake and Booth-encodes the multiplier.
- Generates one partial product per cycle with the team's radix-4 encoder/ppgen datapath, accumulates it with its correction bit into a 2*size accumulator, and presents the product over a valid/ready output handshake.
- Serves as the area-lean multiply resource for PE configurations that do not need one product per cycle.

Parameters:
- size, 8, operand width in bits; even, >= 4.
- CW, derived clog2(size/2) (minimum 1), partial-product counter width; not user-set.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- multiplicand  input  size  signed operand A.
- multiplier  input  size  signed operand B (Booth-encoded).
- abort  input  1  synchronous cancel of the operation in flight.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts the product.
- product  output  2*size  signed A*B, two's complement.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, counter=0, accumulator=0, latched operands=0.
  - product=0, out_valid=0, busy=0, in_ready=1.
- States: IDLE, RUN, DONE, 2-bit encoding.
- Output decode: in_ready=(state==IDLE); out_valid=(state==DONE); busy=(state!=IDLE). All decoded from registered state, no input-to-output combinational path.
- IDLE:
  - On in_valid&&in_ready: latch multiplicand and multiplier, clear accumulator, counter=0, go to RUN.
  - in_valid without a handshake leaves no state change.
- RUN, cycle k (k=0..size/2-1):
  - Booth-encode the group {B[2k+1],B[2k],B[2k-1]}, with B[-1]=0.
  - Form the partial product: 0, +A, +2A, -2A or -A. Negative values are formed as the inverted (size+1)-bit magnitude plus a correction '1' added at bit 2k.
  - Sign-extend the (size+1)-bit partial product to 2*size bits, shift left by 2k, and add it plus the correction to the accumulator, modulo 2^(2*size).
  - Counter increments each cycle. On k==size/2-1, the final accumulation happens in the same cycle, product<=accumulator sum, and state goes to DONE.
- Latency: accept edge at cycle 0; out_valid rises after exactly size/2 further rising edges (4 for size=8).
- DONE:
  - product and out_valid hold stable until out_valid&&out_ready.
  - On that handshake go to IDLE; in_ready=1 the following cycle. No same-cycle accept/retire; back-to-back throughput is one product per size/2+2 cycles.
- product register retains the last result after retire; it changes only at RUN completion or reset.
- Exactness: result equals signed A*B for all inputs, including A=B=-2^(size-1). No overflow is possible in 2*size bits.
- abort (synchronous):
  - In RUN or DONE, abort=1 forces IDLE at the next edge, clears the counter, and leaves product unchanged. A pending result is discarded, out_valid drops.
  - abort in IDLE has no effect, and it also blocks that cycle's in_valid accept: abort has priority over accept.
  - abort and out_ready together in DONE also go to IDLE; the outcome is indistinguishable.
- in_valid while not in IDLE is ignored. The upstream holds operands until in_ready.
- Operands change after the accept edge have no effect on the operation in flight.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values; the operation is lost.

Test Plan:
- Reset asserted mid-RUN (e.g., 2 cycles into a multiply) -> outputs immediately return to product=0, out_valid=0, busy=0, in_ready=1; a subsequent 1*1 yields 0x0001.
- size=8, A=3, B=5, out_ready=1 -> out_valid exactly 4 edges after accept, product=0x000F, in_ready high 1 cycle after retire.
- Corner signs, size=8:
  - A=-128, B=-128 -> 0x4000.
  - A=-128, B=127 -> 0xC080.
  - A=127, B=127 -> 0x3F01.
  - A=-1, B=-1 -> 0x0001.
- Back-pressure: A=-7, B=9 with out_ready=0 for 5 cycles -> out_valid and product=0xFFC1 stay stable throughout; a new in_valid is ignored (in_ready=0); retire when out_ready=1.
- abort asserted 2 cycles into RUN for A=10, B=10 -> IDLE next edge, out_valid never rises, product still holds the previous result; next op A=2, B=-3 -> 0xFFFA.
- Randomized back-to-back: 1000 random signed pairs with random out_ready gaps -> every product equals the reference A*B and the out_valid count equals the accept count.
